hamming_dec_arbiter: RTL
========================

// Module: hamming_dec_arbiter
// PURPOSE
//   Shares one Hamming(12,8) SEC decode datapath between two requesters. A
//   round-robin arbiter grants one codeword at a time, and a small FSM
//   sequences it through capture, syndrome/correct and result hold. Each
//   result is tagged with its requester ID. Saturating per-requester
//   corrected-error counters feed the status path.
// PARAMETERS
//   CNT_W   8   width of each corrected-error counter (saturating)
// PORTS
//   clk        in   1      clock; all state updates on posedge
//   rst        in   1      reset, asynchronous, active-low
//   in_valid   in   2      per-requester codeword valid; bit i = requester i
//   in_data0   in   12     requester 0 codeword; held stable while in_valid[0]
//   in_data1   in   12     requester 1 codeword; held stable while in_valid[1]
//   in_ready   out  2      per-requester grant/ready; at most one bit high
//   out_valid  out  1      decoded result valid
//   out_ready  in   1      downstream accepts result
//   out_id     out  1      requester ID of the current result
//   out_data   out  8      decoded byte {cw[11:8],cw[6:4],cw[2]} after correction
//   out_corr   out  1      single-bit error was corrected
//   out_unc    out  1      syndrome 13..15; data passed uncorrected
//   clr_cnt    in   1      synchronous clear of both counters
//   corr_cnt0  out  CNT_W  corrected-error count, requester 0
//   corr_cnt1  out  CNT_W  corrected-error count, requester 1
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, rr_ptr=0, out_valid=0, out_id=0,
//     out_data=0, out_corr=0, out_unc=0, counters=0, in_ready=0.
//     An in-flight word is dropped, and no counter is updated for it.
//   FSM states: IDLE -> DEC -> HOLD -> IDLE.
//   IDLE:
//     - grant g = rr_ptr if in_valid[rr_ptr], else the other valid requester.
//     - in_ready[g]=1 combinationally; in_ready is 0 in DEC and HOLD.
//     - On in_valid[g]&in_ready[g]: cw_r<=in_data_g, id_r<=g, rr_ptr<=~g,
//       next state DEC.
//     - No valid request: stay in IDLE, rr_ptr unchanged.
//   DEC (one cycle): syndrome s = {p3,p2,p1,p0} computed on cw_r:
//     - p3 = ^cw[11:7]
//     - p2 = cw3^cw4^cw5^cw6^cw11
//     - p1 = cw1^cw2^cw5^cw6^cw9^cw10
//     - p0 = cw0^cw2^cw4^cw6^cw8^cw10
//     - s=0: no flip. s=1..12: flip bit s-1, corr=1. s=13..15: no flip, unc=1.
//     - Registers out_data/out_corr/out_unc/out_id; out_valid<=1; next HOLD.
//   HOLD:
//     - out_* are held stable while out_valid=1 and out_ready=0.
//     - On out_ready: out_valid<=0, next IDLE.
//     - Counter of out_id increments on this handshake if out_corr=1.
//   Latency: input handshake at edge N -> out_valid=1 after edge N+1.
//     Minimum initiation interval is 3 cycles.
//   Counters:
//     - Saturate at 2^CNT_W-1 and never wrap.
//     - clr_cnt beats an increment in the same cycle.
//     - clr_cnt has no effect on FSM or outputs.
//   Simultaneous in_valid=2'b11 alternates grants 0,1,0,1 starting from rr_ptr.
//   out_ready while out_valid=0 is ignored.
// TESTING
//   1. in_valid=01, in_data0=12'h007 -> out_valid 2 cycles after grant,
//      out_data=8'h01, corr=0, unc=0, id=0.
//   2. in_data1=12'h020 (bit 5 flipped from 0) -> s=6, out_data=8'h00,
//      out_corr=1, corr_cnt1=1.
//   3. in_data0=12'h801 -> s=13, out_unc=1, out_data=8'h80, counters unchanged.
//   4. in_valid=11 held for 4 words after reset -> grants 0,1,0,1.
//      out_ready=0 for 5 cycles -> outputs stable, in_ready=00.
//   5. CNT_W=2, 5 corrected words on requester 0 -> corr_cnt0 sticks at 3.
//      clr_cnt coincident with an increment -> 0.
//   6. rst low during DEC -> all outputs 0 immediately.
//      After release, the next request is granted to requester 0.

Source files
------------

// File: rtl/hamming_dec_arbiter.sv
// Two-requester Hamming(12,8) SEC decoder with a shared datapath.
// Round-robin grant, three-state sequencer (IDLE -> DEC -> HOLD), results
// tagged with requester ID, and saturating per-requester corrected-error
// counters.
module hamming_dec_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in_valid,
    input  logic [11:0]      in_data0,
    input  logic [11:0]      in_data1,
    output logic [1:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_id,
    output logic [7:0]       out_data,
    output logic             out_corr,
    output logic             out_unc,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt0,
    output logic [CNT_W-1:0] corr_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Syndrome {p3,p2,p1,p0}; a non-zero value 1..12 is the 1-based position
    // of the flipped bit.
    function automatic logic [3:0] calc_syndrome(input logic [11:0] cw);
        logic [3:0] s;
        s[3] = ^cw[11:7];
        s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6] ^ cw[11];
        s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10];
        s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10];
        return s;
    endfunction

    // Data bits sit at the non-power-of-two positions.
    function automatic logic [7:0] extract_data(input logic [11:0] cw);
        return {cw[11:8], cw[6:4], cw[2]};
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic               rr_ptr_r;
    logic [11:0]        cw_r;
    logic               id_r;
    logic               grant_s;
    logic               take_s;
    logic [1:0]         in_ready_s;
    logic [11:0]        sel_data_s;
    logic [3:0]         syn_s;
    logic [11:0]        flip_mask_s;
    logic               corr_s;
    logic               unc_s;
    logic               out_hs_s;
    logic               inc_s;
    logic               out_valid_r;
    logic               out_id_r;
    logic [7:0]         out_data_r;
    logic               out_corr_r;
    logic               out_unc_r;
    logic [CNT_W-1:0]   cnt0_r;
    logic [CNT_W-1:0]   cnt1_r;

    // Round-robin grant: pointer wins if it is requesting, otherwise the other side.
    always_comb begin
        grant_s    = rr_ptr_r;
        sel_data_s = in_data0;
        if (in_valid[rr_ptr_r]) begin
            grant_s = rr_ptr_r;
        end else begin
            grant_s = ~rr_ptr_r;
        end
        if (grant_s) begin
            sel_data_s = in_data1;
        end else begin
            sel_data_s = in_data0;
        end
    end

    // Next-state logic and the combinational ready/handshake strobes.
    always_comb begin
        next_state_s = state_r;
        in_ready_s   = 2'b00;
        take_s       = 1'b0;
        out_hs_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|in_valid) begin
                    in_ready_s[grant_s] = 1'b1;
                    take_s              = 1'b1;
                    next_state_s        = ST_DEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DEC: begin
                next_state_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_hs_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Syndrome decode of the captured word into a correction mask and flags.
    always_comb begin
        syn_s       = calc_syndrome(cw_r);
        flip_mask_s = 12'h000;
        corr_s      = 1'b0;
        unc_s       = 1'b0;
        if (syn_s == 4'd0) begin
            flip_mask_s = 12'h000;
        end else if (syn_s <= 4'd12) begin
            flip_mask_s = 12'h001 << (syn_s - 4'd1);
            corr_s      = 1'b1;
        end else begin
            unc_s = 1'b1;
        end
    end

    assign inc_s    = out_hs_s & out_corr_r;
    // Ready is forced low while reset is asserted so nothing looks granted.
    assign in_ready = rst ? in_ready_s : 2'b00;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Input capture and round-robin pointer update on an accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cw_r     <= 12'h000;
            id_r     <= 1'b0;
            rr_ptr_r <= 1'b0;
        end else if (take_s) begin
            cw_r     <= sel_data_s;
            id_r     <= grant_s;
            rr_ptr_r <= ~grant_s;
        end else begin
            cw_r     <= cw_r;
            id_r     <= id_r;
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Result registers: loaded in DEC, held through HOLD, valid dropped on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_id_r    <= 1'b0;
            out_data_r  <= 8'h00;
            out_corr_r  <= 1'b0;
            out_unc_r   <= 1'b0;
        end else if (state_r == ST_DEC) begin
            out_valid_r <= 1'b1;
            out_id_r    <= id_r;
            out_data_r  <= extract_data(cw_r ^ flip_mask_s);
            out_corr_r  <= corr_s;
            out_unc_r   <= unc_s;
        end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating corrected-error counters; clear has priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else if (inc_s) begin
            if (!out_id_r && (cnt0_r != CNT_MAX)) begin
                cnt0_r <= cnt0_r + CNT_ONE;
            end else if (out_id_r && (cnt1_r != CNT_MAX)) begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end else begin
                cnt0_r <= cnt0_r;
                cnt1_r <= cnt1_r;
            end
        end else begin
            cnt0_r <= cnt0_r;
            cnt1_r <= cnt1_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_id    = out_id_r;
    assign out_data  = out_data_r;
    assign out_corr  = out_corr_r;
    assign out_unc   = out_unc_r;
    assign corr_cnt0 = cnt0_r;
    assign corr_cnt1 = cnt1_r;

endmodule
